// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and decode helpers for the load/store memory access controller.
package mem_access_ctrl_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned REG_W_DEF = 5;
   localparam int unsigned BE_W      = 4;

   typedef enum logic [2:0] {
      eMsIdle,
      eMsReq,
      eMsWaitRsp,
      eMsWb,
      eMsExc
   } tMemState;

   localparam logic [2:0] eF3Byte  = 3'b000;
   localparam logic [2:0] eF3Half  = 3'b001;
   localparam logic [2:0] eF3Word  = 3'b010;
   localparam logic [2:0] eF3ByteU = 3'b100;
   localparam logic [2:0] eF3HalfU = 3'b101;

   typedef enum logic [1:0] {
      eExcNone     = 2'b00,
      eExcMisalign = 2'b01,
      eExcIllegal  = 2'b10
   } tMemExcCause;

   // Stores only support signed widths; unsigned encodings are load-only.
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      case (f3)
         eF3Byte, eF3Half, eF3Word: return 1'b1;
         eF3ByteU, eF3HalfU:        return !is_store;
         default:                   return 1'b0;
      endcase
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b01:   return a[0];
         2'b10:   return (a != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [BE_W-1:0] gen_be(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   return BE_W'(4'b0001 << a);
         2'b01:   return BE_W'(4'b0011 << a);
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it.
module load_align
   import mem_access_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_addr_lo,
   input  logic [XLEN-1:0] i_rdata,
   output logic [XLEN-1:0] o_data_c
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte   = i_rdata[{i_addr_lo, 3'b000} +: 8];
      w_half   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
      o_data_c = i_rdata;
      case (i_funct3)
         eF3Byte:  o_data_c = {{(XLEN-8){w_byte[7]}}, w_byte};
         eF3ByteU: o_data_c = {{(XLEN-8){1'b0}}, w_byte};
         eF3Half:  o_data_c = {{(XLEN-16){w_half[15]}}, w_half};
         eF3HalfU: o_data_c = {{(XLEN-16){1'b0}}, w_half};
         default:  o_data_c = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Execute-stage load/store sequencer: drives the data-memory handshake,
// formats store lanes, aligns load data and reports access exceptions.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned REG_W = REG_W_DEF
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iReqValid,
   output logic              oReqReady,
   input  logic              iIsStore,
   input  logic [2:0]        iFunct3,
   input  logic [XLEN-1:0]   iAddr,
   input  logic [XLEN-1:0]   iStoreData,
   input  logic [REG_W-1:0]  iRd,
   input  logic              iFlush,
   output logic              oMemReqValid,
   input  logic              iMemReqReady,
   output logic [XLEN-1:0]   oMemAddr,
   output logic              oMemWe,
   output logic [BE_W-1:0]   oMemBe,
   output logic [XLEN-1:0]   oMemWdata,
   input  logic              iMemRspValid,
   input  logic [XLEN-1:0]   iMemRdata,
   output logic              oWbValid,
   output logic [REG_W-1:0]  oWbRd,
   output logic [XLEN-1:0]   oWbData,
   output logic              oStall,
   output logic              oExc,
   output logic [1:0]        oExcCause,
   output logic [XLEN-1:0]   oExcAddr
);

   tMemState          r_state, w_state_nxt;
   logic              r_is_store, w_is_store_nxt;
   logic [2:0]        r_funct3, w_funct3_nxt;
   logic [1:0]        r_alo, w_alo_nxt;
   logic [REG_W-1:0]  r_rd, w_rd_nxt;
   logic              r_discard, w_discard_nxt;

   logic              r_mem_req_valid, w_mem_req_valid_nxt;
   logic [XLEN-1:0]   r_mem_addr, w_mem_addr_nxt;
   logic              r_mem_we, w_mem_we_nxt;
   logic [BE_W-1:0]   r_mem_be, w_mem_be_nxt;
   logic [XLEN-1:0]   r_mem_wdata, w_mem_wdata_nxt;
   logic              r_wb_valid, w_wb_valid_nxt;
   logic [REG_W-1:0]  r_wb_rd, w_wb_rd_nxt;
   logic [XLEN-1:0]   r_wb_data, w_wb_data_nxt;
   logic              r_exc, w_exc_nxt;
   tMemExcCause       r_exc_cause, w_exc_cause_nxt;
   logic [XLEN-1:0]   r_exc_addr, w_exc_addr_nxt;

   logic [XLEN-1:0]   w_wdata_fmt;
   logic [XLEN-1:0]   w_ld_data;

   load_align #(.XLEN(XLEN)) u_load_align (
      .i_funct3  (r_funct3),
      .i_addr_lo (r_alo),
      .i_rdata   (iMemRdata),
      .o_data_c  (w_ld_data)
   );

   // Store data replicated across every lane the byte enables could select.
   always_comb begin
      w_wdata_fmt = iStoreData;
      case (iFunct3[1:0])
         2'b00:   w_wdata_fmt = XLEN'({4{iStoreData[7:0]}});
         2'b01:   w_wdata_fmt = XLEN'({2{iStoreData[15:0]}});
         default: w_wdata_fmt = iStoreData;
      endcase
   end

   always_comb begin
      w_state_nxt         = r_state;
      w_is_store_nxt      = r_is_store;
      w_funct3_nxt        = r_funct3;
      w_alo_nxt           = r_alo;
      w_rd_nxt            = r_rd;
      w_discard_nxt       = r_discard;
      w_mem_req_valid_nxt = r_mem_req_valid;
      w_mem_addr_nxt      = r_mem_addr;
      w_mem_we_nxt        = r_mem_we;
      w_mem_be_nxt        = r_mem_be;
      w_mem_wdata_nxt     = r_mem_wdata;
      w_wb_valid_nxt      = 1'b0;
      w_wb_rd_nxt         = r_wb_rd;
      w_wb_data_nxt       = r_wb_data;
      w_exc_nxt           = 1'b0;
      w_exc_cause_nxt     = r_exc_cause;
      w_exc_addr_nxt      = r_exc_addr;

      case (r_state)
         eMsIdle: begin
            if (iReqValid && !iFlush) begin
               w_is_store_nxt = iIsStore;
               w_funct3_nxt   = iFunct3;
               w_alo_nxt      = iAddr[1:0];
               w_rd_nxt       = iRd;
               w_discard_nxt  = 1'b0;
               if (!f3_legal(iIsStore, iFunct3)) begin
                  w_state_nxt     = eMsExc;
                  w_exc_nxt       = 1'b1;
                  w_exc_cause_nxt = eExcIllegal;
                  w_exc_addr_nxt  = iAddr;
               end else if (f3_misaligned(iFunct3, iAddr[1:0])) begin
                  w_state_nxt     = eMsExc;
                  w_exc_nxt       = 1'b1;
                  w_exc_cause_nxt = eExcMisalign;
                  w_exc_addr_nxt  = iAddr;
               end else begin
                  w_state_nxt         = eMsReq;
                  w_mem_req_valid_nxt = 1'b1;
                  w_mem_addr_nxt      = {iAddr[XLEN-1:2], 2'b00};
                  w_mem_we_nxt        = iIsStore;
                  w_mem_be_nxt        = gen_be(iFunct3, iAddr[1:0]);
                  w_mem_wdata_nxt     = w_wdata_fmt;
               end
            end
         end
         // A completed handshake commits the access even if a flush arrives with it.
         eMsReq: begin
            if (iMemReqReady) begin
               w_state_nxt         = eMsWaitRsp;
               w_mem_req_valid_nxt = 1'b0;
               w_discard_nxt       = iFlush;
            end else if (iFlush) begin
               w_state_nxt         = eMsIdle;
               w_mem_req_valid_nxt = 1'b0;
            end
         end
         eMsWaitRsp: begin
            if (iMemRspValid) begin
               if (r_is_store || r_discard || iFlush) begin
                  w_state_nxt = eMsIdle;
               end else begin
                  w_state_nxt    = eMsWb;
                  w_wb_valid_nxt = (r_rd != '0);
                  w_wb_rd_nxt    = r_rd;
                  w_wb_data_nxt  = w_ld_data;
               end
            end else if (iFlush) begin
               w_discard_nxt = 1'b1;
            end
         end
         eMsWb:   w_state_nxt = eMsIdle;
         eMsExc:  w_state_nxt = eMsIdle;
         default: w_state_nxt = eMsIdle;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         r_state         <= eMsIdle;
         r_is_store      <= 1'b0;
         r_funct3        <= '0;
         r_alo           <= '0;
         r_rd            <= '0;
         r_discard       <= 1'b0;
         r_mem_req_valid <= 1'b0;
         r_mem_addr      <= '0;
         r_mem_we        <= 1'b0;
         r_mem_be        <= '0;
         r_mem_wdata     <= '0;
         r_wb_valid      <= 1'b0;
         r_wb_rd         <= '0;
         r_wb_data       <= '0;
         r_exc           <= 1'b0;
         r_exc_cause     <= eExcNone;
         r_exc_addr      <= '0;
      end else begin
         r_state         <= w_state_nxt;
         r_is_store      <= w_is_store_nxt;
         r_funct3        <= w_funct3_nxt;
         r_alo           <= w_alo_nxt;
         r_rd            <= w_rd_nxt;
         r_discard       <= w_discard_nxt;
         r_mem_req_valid <= w_mem_req_valid_nxt;
         r_mem_addr      <= w_mem_addr_nxt;
         r_mem_we        <= w_mem_we_nxt;
         r_mem_be        <= w_mem_be_nxt;
         r_mem_wdata     <= w_mem_wdata_nxt;
         r_wb_valid      <= w_wb_valid_nxt;
         r_wb_rd         <= w_wb_rd_nxt;
         r_wb_data       <= w_wb_data_nxt;
         r_exc           <= w_exc_nxt;
         r_exc_cause     <= w_exc_cause_nxt;
         r_exc_addr      <= w_exc_addr_nxt;
      end
   end

   assign oReqReady    = (r_state == eMsIdle);
   assign oStall       = (r_state != eMsIdle);
   assign oMemReqValid = r_mem_req_valid;
   assign oMemAddr     = r_mem_addr;
   assign oMemWe       = r_mem_we;
   assign oMemBe       = r_mem_be;
   assign oMemWdata    = r_mem_wdata;
   assign oWbValid     = r_wb_valid;
   assign oWbRd        = r_wb_rd;
   assign oWbData      = r_wb_data;
   assign oExc         = r_exc;
   assign oExcCause    = r_exc_cause;
   assign oExcAddr     = r_exc_addr;

endmodule
